// File: rtl/imem_port_arbiter.sv
// Two-port arbiter in front of a single asynchronous instruction RAM.
// The fetch unit (F, read-only) and the loader/debug port (L, read/write) share the RAM.
// Grants are round-robin, with one transaction in flight at a time.
// Each transaction passes through three states: IDLE (accept), ACCESS (RAM cycle) and RESP (handshake).
// The RAM control pins are driven straight from flops, so the write strobe cannot glitch.
module imem_port_arbiter #(
  parameter int AW    = 3,
  parameter int DW    = 20,
  parameter int DEPTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req_valid,
  output logic          f_req_ready,
  input  logic [AW-1:0] f_req_addr,
  output logic          f_rsp_valid,
  input  logic          f_rsp_ready,
  output logic [DW-1:0] f_rsp_data,
  output logic          f_rsp_err,
  input  logic          l_req_valid,
  output logic          l_req_ready,
  input  logic          l_req_we,
  input  logic [AW-1:0] l_req_addr,
  input  logic [DW-1:0] l_req_wdata,
  output logic          l_rsp_valid,
  input  logic          l_rsp_ready,
  output logic [DW-1:0] l_rsp_data,
  output logic          l_rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // prio / owner encoding: 0 = fetch port, 1 = loader port
  logic prio;
  logic owner;
  logic grant_f;
  logic grant_l;
  logic accept;
  logic rsp_done;
  logic [AW-1:0] sel_addr;

  // Unsigned range check on the full AW-bit address
  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  // Round-robin winner selection; prio only matters when both ports request
  always_comb begin
    grant_f  = f_req_valid & (~l_req_valid | ~prio);
    grant_l  = l_req_valid & (~f_req_valid | prio);
    accept   = (state == S_IDLE) & (f_req_valid | l_req_valid);
    sel_addr = grant_l ? l_req_addr : f_req_addr;
    rsp_done = (state == S_RESP) & (owner ? l_rsp_ready : f_rsp_ready);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one RAM cycle, then hold the response until it is consumed
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept)   state_nxt = S_ACCESS;
      S_ACCESS:               state_nxt = S_RESP;
      S_RESP:   if (rsp_done) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Request-ready outputs; forced low while in reset so nothing looks accepted
  always_comb begin
    f_req_ready = rst_n & (state == S_IDLE) & grant_f;
    l_req_ready = rst_n & (state == S_IDLE) & grant_l;
  end

  // --- accept stage: latch the winner and launch the RAM controls ---
  // The fetch port never writes. The strobe is suppressed for out-of-range addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      if (accept) begin
        owner     <= grant_l;
        prio      <= ~grant_l;
        mem_addr  <= sel_addr;
        mem_wdata <= grant_l ? l_req_wdata : '0;
        mem_we    <= grant_l & l_req_we & in_range(sel_addr);
      end else if (state == S_ACCESS) begin
        mem_we <= 1'b0;
      end
    end
  end

  // --- access/response stage: capture RAM output and run the response handshake ---
  // For a write, the RAM already shows the newly written word by the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rsp_valid <= 1'b0;
      f_rsp_data  <= '0;
      f_rsp_err   <= 1'b0;
      l_rsp_valid <= 1'b0;
      l_rsp_data  <= '0;
      l_rsp_err   <= 1'b0;
    end else begin
      if (state == S_ACCESS) begin
        if (owner) begin
          l_rsp_valid <= 1'b1;
          l_rsp_data  <= in_range(mem_addr) ? mem_rdata : '0;
          l_rsp_err   <= ~in_range(mem_addr);
        end else begin
          f_rsp_valid <= 1'b1;
          f_rsp_data  <= in_range(mem_addr) ? mem_rdata : '0;
          f_rsp_err   <= ~in_range(mem_addr);
        end
      end else if (rsp_done) begin
        if (owner) l_rsp_valid <= 1'b0;
        else       f_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural asynchronous RAM and a response scoreboard.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [2:0]  f_req_addr;
  logic [19:0] f_rsp_data;
  logic        l_req_valid, l_req_ready, l_req_we, l_rsp_valid, l_rsp_ready, l_rsp_err;
  logic [2:0]  l_req_addr;
  logic [19:0] l_req_wdata, l_rsp_data;
  logic [2:0]  mem_addr;
  logic [19:0] mem_wdata, mem_rdata;
  logic        mem_we;

  logic        ram_init;
  logic [19:0] ram [8];
  logic [19:0] exp_ram [8];
  logic        exp_prio;

  typedef struct {
    logic        own;
    logic [19:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.AW(3), .DW(20), .DEPTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we), .l_req_addr(l_req_addr),
    .l_req_wdata(l_req_wdata), .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready),
    .l_rsp_data(l_rsp_data), .l_rsp_err(l_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Asynchronous RAM: combinational read with write-through while the strobe is high
  assign mem_rdata = mem_we ? mem_wdata : ram[mem_addr];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 8; i++) ram[i] <= 20'(20'h11111 * i);
      ram[2] <= 20'h0ABCD;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from IDLE back to IDLE, checked cycle by cycle
  task automatic txn(input logic fv, input logic lv, input logic lwe,
                     input logic [2:0] fa, input logic [2:0] la,
                     input logic [19:0] wd, input int hold);
    logic       win;
    logic [2:0] a;
    logic       wr, inr;
    exp_t       e, got;
    win = (fv && lv) ? exp_prio : lv;
    a   = win ? la : fa;
    wr  = win & lwe;
    inr = (a < 3'd5);
    e.own  = win;
    e.err  = ~inr;
    e.data = !inr ? 20'h0 : (wr ? wd : exp_ram[a]);
    // idle: present the requests and check the combinational grant
    f_req_valid = fv; f_req_addr = fa;
    l_req_valid = lv; l_req_we = lwe; l_req_addr = la; l_req_wdata = wd;
    #1;
    chk("f_req_ready_grant", 32'(f_req_ready), 32'(fv & ~win));
    chk("l_req_ready_grant", 32'(l_req_ready), 32'(win));
    chk("mem_we_idle", 32'(mem_we), 32'd0);
    sb.push_back(e);
    if (wr && inr) exp_ram[a] = wd;
    exp_prio = ~win;
    // access cycle
    @(posedge clk); @(negedge clk);
    chk("mem_addr_access", 32'(mem_addr), 32'(a));
    chk("mem_we_access", 32'(mem_we), 32'(wr & inr));
    chk("rsp_valid_access", 32'(f_rsp_valid | l_rsp_valid), 32'd0);
    chk("req_ready_access", 32'(f_req_ready | l_req_ready), 32'd0);
    // response cycle, optionally stalled
    @(posedge clk); @(negedge clk);
    chk("mem_we_resp", 32'(mem_we), 32'd0);
    chk("owner_rsp_valid", 32'(win ? l_rsp_valid : f_rsp_valid), 32'd1);
    chk("other_rsp_valid", 32'(win ? f_rsp_valid : l_rsp_valid), 32'd0);
    chk("sb_nonempty", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("rsp_data", 32'(win ? l_rsp_data : f_rsp_data), 32'(got.data));
      chk("rsp_err", 32'(win ? l_rsp_err : f_rsp_err), 32'(got.err));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); @(negedge clk);
        chk("hold_valid", 32'(win ? l_rsp_valid : f_rsp_valid), 32'd1);
        chk("hold_data", 32'(win ? l_rsp_data : f_rsp_data), 32'(got.data));
        chk("hold_no_accept", 32'(f_req_ready | l_req_ready), 32'd0);
      end
    end
    if (win) l_rsp_ready = 1'b1; else f_rsp_ready = 1'b1;
    #1;
    chk("resp_no_accept", 32'(f_req_ready | l_req_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    f_rsp_ready = 1'b0; l_rsp_ready = 1'b0;
    chk("rsp_valid_cleared", 32'(f_rsp_valid | l_rsp_valid), 32'd0);
    f_req_valid = 1'b0; l_req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ram_init = 1'b1;
    f_req_valid = 1'b1; l_req_valid = 1'b1; l_req_we = 1'b0;
    f_req_addr = '0; l_req_addr = '0; l_req_wdata = '0;
    f_rsp_ready = 1'b0; l_rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_ram[i] = 20'(20'h11111 * i);
    exp_ram[2] = 20'h0ABCD;
    exp_prio = 1'b0;

    // reset with both requesters asserting
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_f_req_ready", 32'(f_req_ready), 32'd0);
    chk("rst_l_req_ready", 32'(l_req_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rsp_valid", 32'(f_rsp_valid | l_rsp_valid), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rsp_data", 32'(f_rsp_data | l_rsp_data), 32'd0);
    ram_init = 1'b0;
    rst_n = 1'b1;

    // fetch wins first after reset; read of preloaded word
    txn(1'b1, 1'b1, 1'b0, 3'd2, 3'd0, 20'h0, 0);
    // loader write, then fetch readback
    txn(1'b0, 1'b1, 1'b1, 3'd0, 3'd4, 20'hFFFFF, 0);
    txn(1'b1, 1'b0, 1'b0, 3'd4, 3'd0, 20'h0, 0);
    chk("ram4_written", 32'(ram[4]), 32'h0FFFFF);

    // both ports requesting back to back: grants alternate, with a stalled response
    txn(1'b1, 1'b1, 1'b0, 3'd1, 3'd3, 20'h0, 3);
    txn(1'b1, 1'b1, 1'b1, 3'd0, 3'd3, 20'h2468A, 0);
    txn(1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 20'h0, 3);
    txn(1'b1, 1'b1, 1'b0, 3'd1, 3'd3, 20'h0, 0);

    // out-of-range write and reads
    txn(1'b0, 1'b1, 1'b1, 3'd0, 3'd6, 20'h12345, 0);
    chk("ram6_unchanged", 32'(ram[6]), 32'h066666);
    txn(1'b0, 1'b1, 1'b0, 3'd0, 3'd6, 20'h0, 0);
    txn(1'b1, 1'b0, 1'b0, 3'd7, 3'd0, 20'h0, 0);
    txn(1'b1, 1'b0, 1'b0, 3'd5, 3'd0, 20'h0, 0);

    // reset during the ACCESS cycle of a loader write
    l_req_valid = 1'b1; l_req_we = 1'b1; l_req_addr = 3'd1; l_req_wdata = 20'h55555;
    #1;
    chk("abort_accept", 32'(l_req_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("abort_we_before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_dropped", 32'(mem_we), 32'd0);
    chk("abort_req_ready", 32'(l_req_ready), 32'd0);
    l_req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_prio = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("abort_no_rsp", 32'(l_rsp_valid | f_rsp_valid), 32'd0);
    end
    chk("abort_ram1", 32'(ram[1]), 32'h011111);
    txn(1'b1, 1'b1, 1'b0, 3'd0, 3'd1, 20'h0, 0);
    txn(1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 20'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
